layer_act_loader: RTL and testbench
===================================

Name: layer_act_loader

Overview:
Upstream feeder for the Layer stage. It accepts activations one element at a time over a valid/ready stream and packs them into an IN_N-wide vector, using a two-bank ping-pong buffer. It presents each vector to Layer's in_vec with a valid/ready handshake. Layer has no valid signal, so this block also emits layer_out_valid, timed to Layer's fixed pipeline latency.

Parameters:
IN_N, 4, elements per input vector (matches Layer IN_N)
DATA_WIDTH, 8, signed activation width
PIPE_LAT, 2, Layer pipeline stages from in_vec to out_vec

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
s_valid  in  1  input element valid
s_ready  out  1  loader can accept an element
s_data  in  DATA_WIDTH  signed activation element
s_last  in  1  marks the final element of a vector (may be early)
in_vec  out  IN_N*DATA_WIDTH  packed vector to Layer; element i at [i*DATA_WIDTH +: DATA_WIDTH]
vec_valid  out  1  in_vec holds a complete vector
vec_ready  in  1  consumer takes the vector this cycle
layer_out_valid  out  1  Layer out_vec corresponds to a popped vector
err_short  out  1  one-cycle pulse: a vector was closed by s_last before IN_N elements
fill_count  out  $clog2(IN_N+1)  elements written into the current write bank

Behaviour:
- One clock, clk. Reset is synchronous and active-low on rst_n. All state is sampled on the rising edge of clk.
- Reset, applied while rst_n=0 and held on the first edge after release:
  - both banks cleared to 0 and marked empty; write pointer = bank 0; read pointer = bank 0
  - fill_count=0; vec_valid=0; in_vec=0; layer_out_valid=0; err_short=0; latency shift register cleared
  - s_ready forced 0 while rst_n=0
- Accept: an element is accepted when s_valid && s_ready. It is written to slot fill_count of the write bank, and fill_count increments.
- Vector close: a vector closes on the accept of element IN_N-1, or on an accept with s_last=1, whichever comes first.
  - On close: slots above the written index are zeroed in the same cycle; the bank is marked full; the write pointer toggles; fill_count returns to 0.
  - Early close (s_last with fewer than IN_N elements): err_short=1 on the next cycle, for one cycle only.
  - s_last on element IN_N-1: normal close, no error.
  - Elements beyond IN_N cannot occur; a vector always closes at IN_N.
- s_ready = !(write bank full). It is combinational from registered state. It is 0 only when both banks are full.
- Read side:
  - vec_valid = read bank full.
  - in_vec is driven directly from the read-bank register. It is stable while vec_valid && !vec_ready.
  - On vec_valid && vec_ready: the read bank is marked empty and the read pointer toggles.
- Latency: the first cycle vec_valid can be 1 is the cycle after the closing accept (1-cycle fill-to-present latency).
- Ordering: vectors are presented strictly in arrival order. The buffer holds at most 2 vectors.
- Simultaneous close and pop:
  - Both take effect in the same edge.
  - With one bank full, close into the other bank plus pop of the full bank gives zero stalls.
  - With both full, s_ready=0, so no close can happen.
- Full throughput: with vec_ready held high, one vector per IN_N cycles and no bubbles on s_ready.
- layer_out_valid:
  - A PIPE_LAT-deep shift register samples (vec_valid && vec_ready).
  - layer_out_valid is 1 exactly PIPE_LAT cycles after the pop edge, aligned with Layer out_vec for that vector.
  - Back-to-back pops produce back-to-back pulses.
- Reset mid-operation: any partial or full banks and in-flight layer_out_valid bits are discarded with no output pulse. The next accepted element lands in slot 0 of bank 0.
- Arithmetic: none. Data is copied bit-exact, sign is preserved, and padding is exactly 0.

Test Plan:
1. Basic fill. Reset; vec_ready=1; stream 1, 2, 3, 4 on consecutive cycles, s_last on the 4th.
   -> vec_valid=1 the cycle after the 4th accept; in_vec=32'h04030201 (IN_N=4, DW=8); layer_out_valid=1 two cycles after the pop; err_short stays 0.
2. Backpressure. vec_ready=0; stream 8 elements 1..8.
   -> s_ready=0 after the 8th accept and the 9th element is held.
   -> Raise vec_ready: in_vec=32'h04030201 then 32'h08070605; s_ready returns to 1 after the first pop; the 9th element is accepted.
3. Short vector. Stream 5, -3 with s_last on -3.
   -> in_vec=32'h0000FD05; err_short pulses exactly 1 cycle; fill_count=0 afterwards.
4. Simultaneous events. Bank A full with vec_ready=0; close bank B on the same edge vec_ready rises.
   -> A popped, B presented next cycle; s_ready never drops; ordering preserved.
5. Reset mid-fill. Accept 9, 9, then pulse rst_n=0 for 1 cycle; then stream 1, 2, 3, 4.
   -> no vec_valid for the 9s; in_vec=32'h04030201; no spurious layer_out_valid.
6. Throughput. Stream 40 elements continuously with vec_ready=1.
   -> 10 vectors, 10 layer_out_valid pulses, s_ready constantly 1.

Source files
------------

// File: rtl/layer_act_loader.sv
// Packs a valid/ready element stream into IN_N-wide vectors via a two-bank ping-pong buffer for Layer.
// Vector visible 1 cycle after its closing accept; s_ready drops only while both banks hold unpopped vectors.
module layer_act_loader #(
   parameter int IN_N       = 4,
   parameter int DATA_WIDTH = 8,
   parameter int PIPE_LAT   = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic [DATA_WIDTH-1:0]        s_data,
   input  logic                         s_last,
   output logic [IN_N*DATA_WIDTH-1:0]   in_vec,
   output logic                         vec_valid,
   input  logic                         vec_ready,
   output logic                         layer_out_valid,
   output logic                         err_short,
   output logic [$clog2(IN_N+1)-1:0]    fill_count
);
   localparam int CW = $clog2(IN_N+1);
   localparam int VW = IN_N*DATA_WIDTH;

   logic [VW-1:0]       bank_q [2];
   logic [1:0]          full_q;
   logic                wr_ptr_q;
   logic                rd_ptr_q;
   logic [CW-1:0]       fill_q;
   logic                err_q;
   logic [PIPE_LAT-1:0] lat_q;

   logic                accept;
   logic                last_slot;
   logic                close;
   logic                pop;
   logic [VW-1:0]       wr_bank_nxt;
   logic [1:0]          full_nxt;

   assign s_ready         = rst_n && !full_q[wr_ptr_q];
   assign vec_valid       = full_q[rd_ptr_q];
   assign in_vec          = bank_q[rd_ptr_q];
   assign err_short       = err_q;
   assign layer_out_valid = lat_q[PIPE_LAT-1];
   assign fill_count      = fill_q;

   always_comb begin
      accept      = s_valid && s_ready;
      last_slot   = (fill_q == CW'(IN_N-1));
      close       = accept && (s_last || last_slot);
      pop         = vec_valid && vec_ready;
      wr_bank_nxt = bank_q[wr_ptr_q];
      // Slots above the closing index still hold a previous vector's data; clear them on close.
      for (int i = 0; i < IN_N; i++) begin
         if (i == int'(fill_q)) begin
            wr_bank_nxt[i*DATA_WIDTH +: DATA_WIDTH] = s_data;
         end else if (close && (i > int'(fill_q))) begin
            wr_bank_nxt[i*DATA_WIDTH +: DATA_WIDTH] = '0;
         end
      end
      full_nxt = full_q;
      if (pop) begin
         full_nxt[rd_ptr_q] = 1'b0;
      end
      if (close) begin
         full_nxt[wr_ptr_q] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bank_q[0] <= '0;
         bank_q[1] <= '0;
         full_q    <= '0;
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
         fill_q    <= '0;
         err_q     <= 1'b0;
         lat_q     <= '0;
      end else begin
         if (accept) begin
            bank_q[wr_ptr_q] <= wr_bank_nxt;
         end
         full_q <= full_nxt;
         if (pop) begin
            rd_ptr_q <= !rd_ptr_q;
         end
         if (close) begin
            wr_ptr_q <= !wr_ptr_q;
            fill_q   <= '0;
         end else if (accept) begin
            fill_q <= fill_q + CW'(1);
         end
         err_q    <= close && !last_slot;
         lat_q[0] <= pop;
         for (int i = 1; i < PIPE_LAT; i++) begin
            lat_q[i] <= lat_q[i-1];
         end
      end
   end
endmodule

// File: tb/tb_layer_act_loader.sv
// Bench for layer_act_loader: hand-computed vector table, directed corner sequences,
// and random traffic against a queue-based reference model.
module tb_layer_act_loader;
   localparam int IN_N     = 4;
   localparam int DW       = 8;
   localparam int PIPE_LAT = 2;
   localparam int VW       = IN_N*DW;
   localparam bit T = 1'b1;
   localparam bit F = 1'b0;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;
   logic          s_last;
   logic [VW-1:0] in_vec;
   logic          vec_valid;
   logic          vec_ready;
   logic          layer_out_valid;
   logic          err_short;
   logic [2:0]    fill_count;

   always #5 clk = ~clk;

   layer_act_loader #(.IN_N(IN_N), .DATA_WIDTH(DW), .PIPE_LAT(PIPE_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .s_last(s_last), .in_vec(in_vec), .vec_valid(vec_valid), .vec_ready(vec_ready),
      .layer_out_valid(layer_out_valid), .err_short(err_short), .fill_count(fill_count)
   );

   typedef struct {
      logic          rst, v;
      logic [DW-1:0] d;
      logic          l, r;
      logic          e_rdy, e_vld, chk_vec;
      logic [VW-1:0] e_vec;
      logic          e_lov, e_err;
      logic [2:0]    e_fill;
   } vec_t;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc_no   = 0;
   int obs_lov, obs_notrdy, obs_pop;

   // Reference model: completed vectors in arrival order, the partial vector, and a per-cycle pop history.
   logic [VW-1:0] mq[$];
   logic [DW-1:0] part[$];
   bit            pop_log[$];
   bit            m_err;
   bit            e_rdy, e_vld;

   task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc_no, act, exp);
   endtask

   task automatic drive_check(input logic rst, input logic v, input logic [DW-1:0] d,
                              input logic l, input logic r);
      int  n;
      bit  e_lov;
      rst_n = rst; s_valid = v; s_data = d; s_last = l; vec_ready = r;
      #1;
      e_rdy = rst && (mq.size() < 2);
      e_vld = (mq.size() > 0);
      n     = pop_log.size();
      e_lov = (n >= PIPE_LAT) && pop_log[n-PIPE_LAT];
      check("s_ready", s_ready, e_rdy);
      check("vec_valid", vec_valid, e_vld);
      if (e_vld) check("in_vec", in_vec, mq[0]);
      check("fill_count", fill_count, part.size());
      check("err_short", err_short, m_err);
      check("layer_out_valid", layer_out_valid, e_lov);
      if (layer_out_valid) obs_lov++;
      if (!s_ready) obs_notrdy++;
      if (vec_valid && vec_ready) obs_pop++;
   endtask

   task automatic model_reset();
      mq.delete();
      part.delete();
      m_err = 1'b0;
      pop_log.delete();
      repeat (PIPE_LAT) pop_log.push_back(1'b0);
   endtask

   task automatic advance();
      bit            acc, pop;
      logic [VW-1:0] v_new;
      if (!rst_n) begin
         model_reset();
      end else begin
         acc   = s_valid && e_rdy;
         pop   = e_vld && vec_ready;
         m_err = 1'b0;
         pop_log.push_back(pop);
         if (pop) void'(mq.pop_front());
         if (acc) begin
            part.push_back(s_data);
            if (s_last || part.size() == IN_N) begin
               v_new = '0;
               foreach (part[i]) v_new[i*DW +: DW] = part[i];
               m_err = (part.size() < IN_N);
               mq.push_back(v_new);
               part.delete();
            end
         end
      end
      cyc_no++;
      @(negedge clk);
   endtask

   task automatic cyc(input logic rst, input logic v, input logic [DW-1:0] d,
                      input logic l, input logic r);
      drive_check(rst, v, d, l, r);
      advance();
   endtask

   vec_t tbl[15];

   initial begin
      tbl[0]  = '{T, T, 8'h01, F, T, T, F, T, 32'h0,        F, F, 3'd0};
      tbl[1]  = '{T, T, 8'h02, F, T, T, F, F, 32'h0,        F, F, 3'd1};
      tbl[2]  = '{T, T, 8'h03, F, T, T, F, F, 32'h0,        F, F, 3'd2};
      tbl[3]  = '{T, T, 8'h04, T, T, T, F, F, 32'h0,        F, F, 3'd3};
      tbl[4]  = '{T, F, 8'h00, F, T, T, T, T, 32'h04030201, F, F, 3'd0};
      tbl[5]  = '{T, F, 8'h00, F, T, T, F, F, 32'h0,        F, F, 3'd0};
      tbl[6]  = '{T, F, 8'h00, F, T, T, F, F, 32'h0,        T, F, 3'd0};
      tbl[7]  = '{T, F, 8'h00, F, T, T, F, F, 32'h0,        F, F, 3'd0};
      tbl[8]  = '{T, T, 8'h05, F, T, T, F, F, 32'h0,        F, F, 3'd0};
      tbl[9]  = '{T, T, 8'hFD, T, T, T, F, F, 32'h0,        F, F, 3'd1};
      tbl[10] = '{T, F, 8'h00, F, F, T, T, T, 32'h0000FD05, F, T, 3'd0};
      tbl[11] = '{T, F, 8'h00, F, T, T, T, T, 32'h0000FD05, F, F, 3'd0};
      tbl[12] = '{T, F, 8'h00, F, T, T, F, F, 32'h0,        F, F, 3'd0};
      tbl[13] = '{T, F, 8'h00, F, T, T, F, F, 32'h0,        T, F, 3'd0};
      tbl[14] = '{T, F, 8'h00, F, T, T, F, F, 32'h0,        F, F, 3'd0};

      model_reset();
      rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; vec_ready = 1'b0;
      @(negedge clk);
      cyc(F, F, 8'h00, F, F);
      check("reset in_vec", in_vec, '0);
      check("reset fill_count", fill_count, 0);

      // Basic fill and short vector, hand-computed expectations.
      foreach (tbl[k]) begin
         drive_check(tbl[k].rst, tbl[k].v, tbl[k].d, tbl[k].l, tbl[k].r);
         check($sformatf("tbl%0d s_ready", k), s_ready, tbl[k].e_rdy);
         check($sformatf("tbl%0d vec_valid", k), vec_valid, tbl[k].e_vld);
         if (tbl[k].chk_vec) check($sformatf("tbl%0d in_vec", k), in_vec, tbl[k].e_vec);
         check($sformatf("tbl%0d layer_out_valid", k), layer_out_valid, tbl[k].e_lov);
         check($sformatf("tbl%0d err_short", k), err_short, tbl[k].e_err);
         check($sformatf("tbl%0d fill_count", k), fill_count, tbl[k].e_fill);
         advance();
      end

      // Backpressure: two full banks, ninth element held until the first pop.
      for (int k = 1; k <= 8; k++) cyc(T, T, DW'(k), F, F);
      check("bp s_ready low", s_ready, 0);
      check("bp first vec", in_vec, 32'h04030201);
      cyc(T, T, 8'h09, F, F);
      cyc(T, T, 8'h09, F, F);
      check("bp ninth held", fill_count, 0);
      cyc(T, T, 8'h09, F, T);
      check("bp second vec", in_vec, 32'h08070605);
      check("bp s_ready back", s_ready, 1);
      cyc(T, T, 8'h09, F, T);
      check("bp ninth accepted", fill_count, 1);
      for (int k = 10; k <= 12; k++) cyc(T, T, DW'(k), F, T);
      repeat (3) cyc(T, F, 8'h00, F, T);

      // Close of bank B on the same edge that pops bank A.
      obs_notrdy = 0;
      for (int k = 0; k < 4; k++) cyc(T, T, DW'(8'h11 + k), F, F);
      for (int k = 0; k < 3; k++) cyc(T, T, DW'(8'h21 + k), F, F);
      cyc(T, T, 8'h24, F, T);
      check("simul s_ready drops", obs_notrdy, 0);
      check("simul vec_valid", vec_valid, 1);
      check("simul in_vec B", in_vec, 32'h24232221);
      repeat (3) cyc(T, F, 8'h00, F, T);

      // Reset with one vector popped in flight and a partial vector pending.
      for (int k = 0; k < 4; k++) cyc(T, T, DW'(8'h31 + k), F, F);
      cyc(T, T, 8'h09, F, F);
      cyc(T, T, 8'h09, F, T);
      cyc(F, F, 8'h00, F, F);
      check("rst vec_valid", vec_valid, 0);
      check("rst fill_count", fill_count, 0);
      check("rst in_vec", in_vec, '0);
      obs_lov = 0;
      for (int k = 1; k <= 4; k++) cyc(T, T, DW'(k), F, F);
      check("rst new vec", in_vec, 32'h04030201);
      repeat (4) cyc(T, F, 8'h00, F, T);
      check("rst lov pulses", obs_lov, 1);

      // Throughput: 40 elements back to back with the consumer always ready.
      obs_lov = 0; obs_notrdy = 0; obs_pop = 0;
      repeat (40) cyc(T, T, DW'($urandom), F, T);
      repeat (4) cyc(T, F, 8'h00, F, T);
      check("tput pops", obs_pop, 10);
      check("tput lov pulses", obs_lov, 10);
      check("tput s_ready drops", obs_notrdy, 0);

      // Random traffic against the model.
      for (int k = 0; k < 3000; k++) begin
         cyc(($urandom_range(0, 299) != 0), ($urandom_range(0, 3) != 0), DW'($urandom),
             ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) != 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
